// File: rtl/xbus_decoder.sv
// xbus_decoder: address decoder and response sequencer for a single-master bus.
// Build option: define XBUS_TIMEOUT_EN to abort stalled BUSY accesses after TO_CYC cycles.
// Ports: clk, rst (async, high); sel/addr master request; slv_sel one-hot select;
//        slv_rdata/slv_ready per-slave data/done; data_to_rd registered read data;
//        ready one-cycle completion; trap_sel/err_code error pulse (1 unmapped, 2 timeout).
module xbus_decoder #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int N_SLV  = 8,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [N_SLV*5-1:0]      SLV_OW   = '0,
  parameter int TO_CYC = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sel,
  input  logic [ADDR_W-1:0]       addr,
  output logic [N_SLV-1:0]        slv_sel,
  input  logic [N_SLV*DATA_W-1:0] slv_rdata,
  input  logic [N_SLV-1:0]        slv_ready,
  output logic [DATA_W-1:0]       data_to_rd,
  output logic                    ready,
  output logic                    trap_sel,
  output logic [1:0]              err_code
);

  localparam int IW = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IW-1:0]     hit_idx;
  logic              hit;
  logic              to_hit;

  function automatic logic slv_match(
    input logic [ADDR_W-1:0] a,
    input int                i
  );
    logic [ADDR_W-1:0] msk;
    msk = ~((ADDR_W'(1) << SLV_OW[i*5 +: 5]) - ADDR_W'(1));
    return (a & msk) == SLV_BASE[i*ADDR_W +: ADDR_W];
  endfunction

  // Scan high to low so the lowest matching index is the one kept.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (slv_match(addr, i)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

`ifdef XBUS_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // cnt_q counts completed BUSY cycles; this is the last allowed one.
  assign to_hit = (cnt_q == 8'(TO_CYC - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    data_d  = data_q;
`ifdef XBUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (sel) begin
          if (hit) begin
            idx_d   = hit_idx;
            err_d   = 2'd0;
            state_d = BUSY;
`ifdef XBUS_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
          end else begin
            err_d   = 2'd1;
            data_d  = '0;
            state_d = RESP;
          end
        end
      end
      BUSY: begin
        // A slave completion beats a timeout landing on the same cycle.
        if (slv_ready[idx_q]) begin
          data_d  = slv_rdata[idx_q*DATA_W +: DATA_W];
          err_d   = 2'd0;
          state_d = RESP;
        end else if (to_hit) begin
          data_d  = '0;
          err_d   = 2'd2;
          state_d = RESP;
        end else begin
`ifdef XBUS_TIMEOUT_EN
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= 2'd0;
      data_q  <= '0;
`ifdef XBUS_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      data_q  <= data_d;
`ifdef XBUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Outputs decode from state only, so reset clears them at once.
  assign slv_sel    = (state_q == BUSY) ? (N_SLV'(1) << idx_q) : '0;
  assign ready      = (state_q == RESP);
  assign trap_sel   = ready && (err_q != 2'd0);
  assign err_code   = ready ? err_q : 2'd0;
  assign data_to_rd = data_q;

endmodule

// File: tb/tb_xbus_decoder.sv
// tb_xbus_decoder: directed bench for xbus_decoder with a transaction-level model.
// Every negedge compares the DUT against the model; directed checks pin literals.
module tb_xbus_decoder;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          sel;
  logic [AW-1:0] addr;
  logic [NS-1:0] slv_ready;
  logic [NS*DW-1:0] slv_rdata;

  logic [NS-1:0] slv_sel, slv_sel2;
  logic [DW-1:0] data_to_rd, data2;
  logic          ready, ready2;
  logic          trap_sel, trap2;
  logic [1:0]    err_code, err2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  xbus_decoder #(
    .ADDR_W(AW), .DATA_W(DW), .N_SLV(NS),
    .SLV_BASE({13'h300, 13'h200, 13'h100, 13'h000}),
    .SLV_OW({5'd8, 5'd8, 5'd8, 5'd8}),
    .TO_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .addr(addr),
    .slv_sel(slv_sel), .slv_rdata(slv_rdata), .slv_ready(slv_ready),
    .data_to_rd(data_to_rd), .ready(ready),
    .trap_sel(trap_sel), .err_code(err_code)
  );

  // Slaves 0 and 2 overlap: both claim 0x000-0x01F.
  xbus_decoder #(
    .ADDR_W(AW), .DATA_W(DW), .N_SLV(NS),
    .SLV_BASE({13'h300, 13'h000, 13'h100, 13'h000}),
    .SLV_OW({5'd8, 5'd5, 5'd8, 5'd8}),
    .TO_CYC(TO)
  ) dut2 (
    .clk(clk), .rst(rst), .sel(sel), .addr(addr),
    .slv_sel(slv_sel2), .slv_rdata(slv_rdata), .slv_ready(slv_ready),
    .data_to_rd(data2), .ready(ready2),
    .trap_sel(trap2), .err_code(err2)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model address map for the main DUT.
  int base_a[NS] = '{'h000, 'h100, 'h200, 'h300};
  int ow_a[NS]   = '{8, 8, 8, 8};

  function automatic int find_slv(input int a);
    for (int i = 0; i < NS; i++) begin
      if (a - (a % (1 << ow_a[i])) == base_a[i]) return i;
    end
    return -1;
  endfunction

  int          m_cur  = -1;
  bit          m_done = 1'b0;
  int          m_err  = 0;
  logic [31:0] m_data = '0;
  int          m_wait = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cur  <= -1;
      m_done <= 1'b0;
      m_err  <= 0;
      m_data <= '0;
      m_wait <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_cur >= 0) begin
      if (slv_ready[m_cur]) begin
        m_data <= slv_rdata[m_cur*DW +: DW];
        m_err  <= 0;
        m_done <= 1'b1;
        m_cur  <= -1;
      end
`ifdef XBUS_TIMEOUT_EN
      else if (m_wait + 1 == TO) begin
        m_data <= '0;
        m_err  <= 2;
        m_done <= 1'b1;
        m_cur  <= -1;
      end
`endif
      else begin
        m_wait <= m_wait + 1;
      end
    end else if (sel) begin
      m_wait <= 0;
      m_cur  <= find_slv(int'(addr));
      if (find_slv(int'(addr)) < 0) begin
        m_err  <= 1;
        m_data <= '0;
        m_done <= 1'b1;
      end
    end
  end

  logic [39:0] exp_v;
  always @(negedge clk) begin
    exp_v[39:36] = (m_cur >= 0) ? 4'(1 << m_cur) : 4'd0;
    exp_v[35]    = m_done;
    exp_v[34]    = m_done && (m_err != 0);
    exp_v[33:32] = m_done ? 2'(m_err) : 2'd0;
    exp_v[31:0]  = m_data;
    chk("cycle", 64'({slv_sel, ready, trap_sel, err_code, data_to_rd}),
        64'(exp_v));
  end

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    addr = '0;
    slv_ready = '0;
    slv_rdata = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
    repeat (2) @(negedge clk);
    chk("rst_sel", 64'(slv_sel), 64'(0));
    chk("rst_rdy", 64'(ready), 64'(0));
    chk("rst_data", 64'(data_to_rd), 64'(0));
    chk("rst_err", 64'(err_code), 64'(0));
    rst = 1'b0;

    // Basic read from slave 1.
    @(negedge clk);
    addr = 13'h1A4; sel = 1'b1; slv_ready = 4'b0010;
    @(negedge clk);
    chk("t1_sel", 64'(slv_sel), 64'(4'b0010));
    chk("t1_rdy0", 64'(ready), 64'(0));
    sel = 1'b0;
    @(negedge clk);
    chk("t1_rdy", 64'(ready), 64'(1));
    chk("t1_data", 64'(data_to_rd), 64'(32'hCAFE0001));
    chk("t1_err", 64'(err_code), 64'(0));
    chk("t1_sel0", 64'(slv_sel), 64'(0));
    slv_ready = '0;
    @(negedge clk);
    chk("t1_hold", 64'(data_to_rd), 64'(32'hCAFE0001));
    chk("t1_rdyoff", 64'(ready), 64'(0));

    // Unmapped; sel kept high through RESP must be resampled in IDLE.
    addr = 13'h1FFF; sel = 1'b1;
    @(negedge clk);
    chk("t2_rdy", 64'(ready), 64'(1));
    chk("t2_trap", 64'(trap_sel), 64'(1));
    chk("t2_err", 64'(err_code), 64'(1));
    chk("t2_data", 64'(data_to_rd), 64'(0));
    chk("t2_sel", 64'(slv_sel), 64'(0));
    addr = 13'h1A4;
    @(negedge clk);
    chk("t2_idle", 64'(slv_sel), 64'(0));
    @(negedge clk);
    chk("t2_resel", 64'(slv_sel), 64'(4'b0010));
    sel = 1'b0; slv_ready = 4'b0010;
    @(negedge clk);
    chk("t2_data2", 64'(data_to_rd), 64'(32'hCAFE0001));
    slv_ready = '0;
    @(negedge clk);

    // Overlapping map: lowest index wins.
    addr = 13'h010; sel = 1'b1;
    @(negedge clk);
    chk("t3_sel2", 64'(slv_sel2), 64'(4'b0001));
    sel = 1'b0; slv_ready = 4'b0001;
    @(negedge clk);
    chk("t3_rdy2", 64'(ready2), 64'(1));
    chk("t3_data2", 64'(data2), 64'(32'hCAFE0000));
    slv_ready = '0;
    @(negedge clk);

    // Non-selected slave ready ignored; addr/sel changes ignored while busy.
    addr = 13'h150; sel = 1'b1; slv_ready = 4'b1000;
    @(negedge clk);
    addr = 13'h2AA;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_wait", 64'({slv_sel, ready}), 64'({4'b0010, 1'b0}));
    end
    sel = 1'b0; slv_ready = 4'b1010;
    @(negedge clk);
    chk("t4_rdy", 64'(ready), 64'(1));
    chk("t4_data", 64'(data_to_rd), 64'(32'hCAFE0001));
    slv_ready = '0;
    @(negedge clk);

`ifdef XBUS_TIMEOUT_EN
    addr = 13'h3A0; sel = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t5_busy", 64'({slv_sel, ready}), 64'({4'b1000, 1'b0}));
      sel = 1'b0;
    end
    @(negedge clk);
    chk("t5_rdy", 64'(ready), 64'(1));
    chk("t5_trap", 64'(trap_sel), 64'(1));
    chk("t5_err", 64'(err_code), 64'(2));
    chk("t5_data", 64'(data_to_rd), 64'(0));
    @(negedge clk);
    addr = 13'h3A0; sel = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t6_busy", 64'(slv_sel), 64'(4'b1000));
      sel = 1'b0;
      if (k == 4) slv_ready = 4'b1000;
    end
    @(negedge clk);
    chk("t6_rdy", 64'(ready), 64'(1));
    chk("t6_err", 64'(err_code), 64'(0));
    chk("t6_data", 64'(data_to_rd), 64'(32'hCAFE0003));
`else
    addr = 13'h3A0; sel = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk("t5_busy", 64'({slv_sel, ready}), 64'({4'b1000, 1'b0}));
      sel = 1'b0;
    end
    slv_ready = 4'b1000;
    @(negedge clk);
    chk("t5_rdy", 64'(ready), 64'(1));
    chk("t5_err", 64'(err_code), 64'(0));
    chk("t5_data", 64'(data_to_rd), 64'(32'hCAFE0003));
`endif
    slv_ready = '0;
    @(negedge clk);

    // Asynchronous reset in BUSY, then request on first edge after release.
    addr = 13'h1A4; sel = 1'b1;
    @(negedge clk);
    chk("t7_busy", 64'(slv_sel), 64'(4'b0010));
    sel = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t7_sel", 64'(slv_sel), 64'(0));
    chk("t7_rdy", 64'(ready), 64'(0));
    chk("t7_trap", 64'(trap_sel), 64'(0));
    chk("t7_err", 64'(err_code), 64'(0));
    chk("t7_data", 64'(data_to_rd), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    addr = 13'h2A4; sel = 1'b1; slv_ready = 4'b0100;
    @(negedge clk);
    chk("t8_sel", 64'(slv_sel), 64'(4'b0100));
    sel = 1'b0;
    @(negedge clk);
    chk("t8_rdy", 64'(ready), 64'(1));
    chk("t8_data", 64'(data_to_rd), 64'(32'hCAFE0002));
    slv_ready = '0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
